// File: rtl/pc_pkg.sv
// pc_pkg: shared constants and types for the instruction-fetch program counter.
// Contents: next-PC source encodings, fault flag encodings, FSM state type and
// the default reset / instruction-memory placement constants.
package pc_pkg;

  // next-PC source select
  localparam logic [1:0] NPC_SEQ = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;

  // fault flags; both bits set means misaligned and out of range
  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } pc_state_e;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_IMEM_BASE  = 32'h0000_3000;
  localparam int unsigned DEF_IMEM_WORDS = 4096;

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: fetch-side bundle between the core control and the PC unit.
// master: control / datapath side (drives stall, npc_sel, branch and jump info)
// slave : pc_unit (drives pc, pc_plus4, pc_hi, halted, fault, retire_cnt)
interface pc_unit_if;
  logic        stall;
  logic [1:0]  npc_sel;
  logic        br_taken;
  logic [15:0] br_offset;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [3:0]  pc_hi;
  logic        halted;
  logic [1:0]  fault;
  logic [31:0] retire_cnt;

  modport master (
    output stall, npc_sel, br_taken, br_offset, jump_target, jr_target,
    input  pc, pc_plus4, pc_hi, halted, fault, retire_cnt
  );

  modport slave (
    input  stall, npc_sel, br_taken, br_offset, jump_target, jr_target,
    output pc, pc_plus4, pc_hi, halted, fault, retire_cnt
  );
endinterface

// File: rtl/pc_unit_npc_calc.sv
// npc_calc: combinational next-PC mux, branch adder and fetch legality check.
// Inputs : pc_plus4, npc_sel, br_taken, br_offset, jump_target, jr_target
// Outputs: npc (selected next PC), flags (FAULT_* bits, zero when npc is legal)
module npc_calc
  import pc_pkg::*;
#(
  parameter logic [31:0] IMEM_BASE  = DEF_IMEM_BASE,
  parameter int unsigned IMEM_WORDS = DEF_IMEM_WORDS
) (
  input  logic [31:0] pc_plus4,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [15:0] br_offset,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  output logic [31:0] npc,
  output logic [1:0]  flags
);

  // one past the last legal byte; 33 bits so a memory ending at 4 GiB still compares
  localparam logic [32:0] IMEM_END = {1'b0, IMEM_BASE} + ({1'b0, 32'(IMEM_WORDS)} << 2);

  logic [31:0] br_ext;

  assign br_ext = {{14{br_offset[15]}}, br_offset, 2'b00};

  always_comb begin
    npc = pc_plus4;
    case (npc_sel)
      NPC_SEQ: npc = pc_plus4;
      NPC_BR:  npc = br_taken ? (pc_plus4 + br_ext) : pc_plus4;
      NPC_J:   npc = jump_target;
      NPC_JR:  npc = jr_target;
      default: npc = pc_plus4;
    endcase
  end

  always_comb begin
    flags = FAULT_NONE;
    if (npc[1:0] != 2'b00) flags = flags | FAULT_MISALIGN;
    if (({1'b0, npc} < {1'b0, IMEM_BASE}) || ({1'b0, npc} >= IMEM_END))
      flags = flags | FAULT_RANGE;
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: instruction-fetch program counter with fault halt.
// Ports: clk, reset (sync, active-high), bus (pc_unit_if.slave) carrying
// stall/npc_sel/branch/jump inputs and pc/pc_plus4/pc_hi/halted/fault/retire_cnt.
// Build option: PC_RETIRE_CNT_EN adds a 32-bit retire counter; without it
// retire_cnt reads as zero.
//
// state   | meaning
// ST_RUN  | fetching; pc advances to npc unless stalled or npc is illegal
// ST_HALT | stopped on a fetch fault; pc/fault/retire_cnt frozen until reset
module pc_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] IMEM_BASE  = DEF_IMEM_BASE,
  parameter int unsigned IMEM_WORDS = DEF_IMEM_WORDS
) (
  input logic    clk,
  input logic    reset,
  pc_unit_if.slave bus
);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  fault_q, fault_d;
  logic [31:0] pc_plus4;
  logic [31:0] npc;
  logic [1:0]  flags;
  logic        advance;

  assign pc_plus4 = pc_q + 32'd4;

  npc_calc #(
    .IMEM_BASE  (IMEM_BASE),
    .IMEM_WORDS (IMEM_WORDS)
  ) u_npc_calc (
    .pc_plus4    (pc_plus4),
    .npc_sel     (bus.npc_sel),
    .br_taken    (bus.br_taken),
    .br_offset   (bus.br_offset),
    .jump_target (bus.jump_target),
    .jr_target   (bus.jr_target),
    .npc         (npc),
    .flags       (flags)
  );

  // legality is only looked at on an unstalled RUN cycle
  assign advance = (state_q == ST_RUN) && !bus.stall && (flags == FAULT_NONE);

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    pc_d    = advance ? npc : pc_q;
    case (state_q)
      ST_RUN: begin
        if (!bus.stall && (flags != FAULT_NONE)) begin
          fault_d = flags;
          state_d = ST_HALT;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      fault_q <= FAULT_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

`ifdef PC_RETIRE_CNT_EN
  logic [31:0] retire_q, retire_d;

  always_comb begin
    retire_d = retire_q;
    if (advance) retire_d = retire_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) retire_q <= 32'd0;
    else       retire_q <= retire_d;
  end

  assign bus.retire_cnt = retire_q;
`else
  assign bus.retire_cnt = 32'd0;
`endif

  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_plus4;
  assign bus.pc_hi    = pc_plus4[31:28];
  assign bus.halted   = (state_q == ST_HALT);
  assign bus.fault    = fault_q;

endmodule
